// File: rtl/expmod_serial.sv
// expmod_serial: modular exponentiation R = X^E mod M.
// The core walks E from MSB to LSB with square-and-multiply. Each modular
// product uses a bit-serial interleaved multiplier, one multiplier bit per
// cycle, so every square or multiply takes exactly N cycles.
//
// Ports:
//   refclk, rstn               clock, synchronous active-low reset
//   X, E, M                    base (< M), exponent, modulus (>= 2); captured on accept
//   R                          registered result; holds until the next completion
//   req_valid/req_ready        request handshake; req_busy is high while computing
//   res_valid/res_ready        result handshake
module expmod_serial #(
    parameter int N = 255
) (
    input  logic         refclk,
    input  logic         rstn,
    input  logic [N-1:0] X,
    input  logic [N-1:0] E,
    input  logic [N-1:0] M,
    output logic [N-1:0] R,
    input  logic         req_valid,
    output logic         req_ready,
    output logic         req_busy,
    output logic         res_valid,
    input  logic         res_ready
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] TOP = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  x_q, x_d, e_q, e_d, m_q, m_d;
    logic [N-1:0]  acc_q, acc_d, p_q, p_d, r_q, r_d;
    logic [IW-1:0] i_q, i_d, j_q, j_d;
    logic          req_ready_q, req_ready_d, busy_q, busy_d;
    logic          res_valid_q, res_valid_d, arm_q, arm_d;

    // Multiplier step temporaries, one bit wider than the operands so the
    // doubled partial product and the partial sum never overflow.
    logic [N:0]    t1, t2, m_ext;
    logic [N-1:0]  mul_b;
    logic          mul_bit;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        e_d         = e_q;
        m_d         = m_q;
        acc_d       = acc_q;
        p_d         = p_q;
        r_d         = r_q;
        i_d         = i_q;
        j_d         = j_q;
        req_ready_d = req_ready_q;
        busy_d      = busy_q;
        res_valid_d = res_valid_q;
        arm_d       = arm_q;

        // Multiplicand is always acc; multiplier is acc (square) or X (multiply).
        m_ext   = {1'b0, m_q};
        mul_b   = (state_q == MUL) ? x_q : acc_q;
        mul_bit = mul_b[j_q];
        t1      = {p_q, 1'b0};
        if (t1 >= m_ext) t1 = t1 - m_ext;
        t2      = t1 + (mul_bit ? {1'b0, acc_q} : '0);
        if (t2 >= m_ext) t2 = t2 - m_ext;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    x_d         = X;
                    e_d         = E;
                    m_d         = M;
                    acc_d       = N'(1);
                    p_d         = '0;
                    i_d         = TOP;
                    j_d         = TOP;
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = SQR;
                end
            end
            SQR, MUL: begin
                p_d = t2[N-1:0];
                j_d = j_q - 1'b1;
                if (j_q == '0) begin
                    // Product complete: commit to acc and decide the next op.
                    acc_d = t2[N-1:0];
                    p_d   = '0;
                    j_d   = TOP;
                    if (state_q == SQR && e_q[i_q]) begin
                        state_d = MUL;
                    end else if (i_q == '0) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        r_d     = t2[N-1:0];
                    end else begin
                        i_d     = i_q - 1'b1;
                        state_d = SQR;
                    end
                end
            end
            DONE: begin
                if (res_valid_q) begin
                    if (res_ready) begin
                        res_valid_d = 1'b0;
                        arm_d       = 1'b0;
                        req_ready_d = 1'b1;
                        state_d     = IDLE;
                    end
                end else if (!arm_q) begin
                    // One settle cycle after DONE entry so R is stable a full
                    // cycle before res_valid can be raised.
                    arm_d = 1'b1;
                end else if (!res_ready) begin
                    res_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge refclk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            x_q         <= '0;
            e_q         <= '0;
            m_q         <= '0;
            acc_q       <= '0;
            p_q         <= '0;
            r_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            arm_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            e_q         <= e_d;
            m_q         <= m_d;
            acc_q       <= acc_d;
            p_q         <= p_d;
            r_q         <= r_d;
            i_q         <= i_d;
            j_q         <= j_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            arm_q       <= arm_d;
        end
    end

    assign R         = r_q;
    assign req_ready = req_ready_q;
    assign req_busy  = busy_q;
    assign res_valid = res_valid_q;

endmodule

// File: tb/tb_expmod_serial.sv
// Testbench for expmod_serial at N=8: directed and random operations checked
// against a repeated-multiplication reference model and a closed-form latency.
module tb_expmod_serial;
    localparam int N = 8;

    logic         refclk = 1'b0;
    logic         rstn = 1'b0;
    logic [N-1:0] X = '0, E = '0, M = '0;
    logic [N-1:0] R;
    logic         req_valid = 1'b0, req_ready, req_busy, res_valid;
    logic         res_ready = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    expmod_serial #(.N(N)) dut (
        .refclk(refclk), .rstn(rstn), .X(X), .E(E), .M(M), .R(R),
        .req_valid(req_valid), .req_ready(req_ready), .req_busy(req_busy),
        .res_valid(res_valid), .res_ready(res_ready)
    );

    always #5 refclk = ~refclk;
    always @(posedge refclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // X^E mod M by E repeated multiplications.
    function automatic longint model(input int x, input int e, input int m);
        longint r = 1 % m;
        for (int k = 0; k < e; k++) r = (r * x) % m;
        return r;
    endfunction

    function automatic int lat_model(input logic [N-1:0] e);
        return N * (N + $countones(e)) + 2;
    endfunction

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    // One full request/result transaction with res_ready held low until the
    // result appears. Optionally scrambles X/E/M after acceptance.
    task automatic run_op(input string tag, input logic [N-1:0] x, input logic [N-1:0] e,
                          input logic [N-1:0] m, input bit scramble);
        int acc_cyc, busy_n, lat;
        bit seen;
        X = x; E = e; M = m; req_valid = 1'b1; res_ready = 1'b0;
        tick();                       // accepting edge
        acc_cyc = cyc;
        req_valid = 1'b0;
        busy_n = 0;
        seen = 0;
        for (int k = 0; k < 4000; k++) begin
            if (scramble) begin
                X = N'($urandom); E = N'($urandom); M = N'($urandom);
            end
            if (req_busy) busy_n++;
            if (res_valid) begin seen = 1; break; end
            tick();
        end
        lat = cyc - acc_cyc;
        chk({tag, "_seen"}, seen, 1);
        chk({tag, "_lat"}, lat, lat_model(e));
        chk({tag, "_busy"}, busy_n, lat_model(e) - 2);
        chk({tag, "_R"}, R, model(x, e, m));
        res_ready = 1'b1;
        tick();
        chk({tag, "_vdrop"}, res_valid, 0);
        chk({tag, "_rdy"}, req_ready, 1);
        res_ready = 1'b0;
        tick();
    endtask

    initial begin
        logic [N-1:0] rx, re, rm;
        int got, rises;
        bit prev_v;

        repeat (3) tick();
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", req_busy, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_R", R, 0);
        rstn = 1'b1;
        tick();

        run_op("t3e5", 8'd3, 8'd5, 8'd251, 0);
        chk("t3e5_const", R, 243);
        run_op("e0", 8'd7, 8'd0, 8'd251, 0);
        chk("e0_const", R, 1);
        run_op("x0", 8'd0, 8'd5, 8'd251, 0);
        run_op("scr", 8'd100, 8'd200, 8'd233, 1);
        run_op("full", 8'd254, 8'hFF, 8'd255, 0);

        for (int n = 0; n < 6; n++) begin
            rm = N'($urandom_range(2, 255));
            rx = N'($urandom_range(0, int'(rm) - 1));
            re = N'($urandom);
            run_op("rnd", rx, re, rm, 0);
        end

        // res_ready held high across DONE entry: result must wait for it to drop.
        X = 8'd5; E = 8'd3; M = 8'd13; req_valid = 1'b1; res_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 2000 && req_busy; k++) tick();
        repeat (5) tick();
        chk("hold_valid", res_valid, 0);
        res_ready = 1'b0;
        tick();
        tick();
        chk("hold_rise", res_valid, 1);
        chk("hold_R", R, model(5, 3, 13));
        res_ready = 1'b1;
        tick();
        chk("hold_drop", res_valid, 0);
        res_ready = 1'b0;
        tick();

        // Harness loop: req_valid tied high, res_ready pulsed per result.
        X = 8'd9; E = 8'd77; M = 8'd241; req_valid = 1'b1;
        got = 0; rises = 0; prev_v = 0;
        for (int k = 0; k < 4000 && got < 4; k++) begin
            tick();
            if (res_valid && !prev_v) rises++;
            prev_v = res_valid;
            if (res_valid && !res_ready) begin
                chk("b2b_R", R, model(9, 77, 241));
                got++;
                res_ready = 1'b1;
                if (got == 4) req_valid = 1'b0;
            end else begin
                res_ready = 1'b0;
            end
        end
        tick();
        res_ready = 1'b0;
        chk("b2b_got", got, 4);
        chk("b2b_rises", rises, 4);
        repeat (3) tick();
        chk("b2b_idle", req_ready, 1);
        chk("b2b_nobusy", req_busy, 0);

        // Reset in the middle of a squaring.
        X = 8'd3; E = 8'd5; M = 8'd251; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (10) tick();
        rstn = 1'b0;
        tick();
        chk("mrst_ready", req_ready, 1);
        chk("mrst_busy", req_busy, 0);
        chk("mrst_valid", res_valid, 0);
        chk("mrst_R", R, 0);
        rstn = 1'b1;
        tick();
        run_op("post", 8'd3, 8'd5, 8'd251, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
